// File: rtl/ctrl_sequencer_pkg.sv
// Package cpu_ctrl_pkg: shared definitions for the hardwired control sequencer.
//   - instruction-word geometry (IR_W, OPC_LSB, OPC_W)
//   - 5-bit opcode constants
//   - ALU function codes (alu_op_e)
//   - FSM state encoding (state_e: RST, T0..T7, HALT)
//   - decoded instruction classes (iclass_e)
//   - ctrl_t: bundle of every control strobe driven by the sequencer
package cpu_ctrl_pkg;

    localparam int unsigned IR_W    = 32;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned OPC_W   = 5;

    localparam logic [OPC_W-1:0] OpcLd   = 5'b00000;
    localparam logic [OPC_W-1:0] OpcLdi  = 5'b00001;
    localparam logic [OPC_W-1:0] OpcSt   = 5'b00010;
    localparam logic [OPC_W-1:0] OpcAdd  = 5'b00011;
    localparam logic [OPC_W-1:0] OpcSub  = 5'b00100;
    localparam logic [OPC_W-1:0] OpcAnd  = 5'b00101;
    localparam logic [OPC_W-1:0] OpcOr   = 5'b00110;
    localparam logic [OPC_W-1:0] OpcAddi = 5'b01011;
    localparam logic [OPC_W-1:0] OpcAndi = 5'b01100;
    localparam logic [OPC_W-1:0] OpcOri  = 5'b01101;
    localparam logic [OPC_W-1:0] OpcBr   = 5'b10010;
    localparam logic [OPC_W-1:0] OpcJr   = 5'b10011;
    localparam logic [OPC_W-1:0] OpcNop  = 5'b11010;
    localparam logic [OPC_W-1:0] OpcHalt = 5'b11011;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3
    } alu_op_e;

    typedef enum logic [3:0] {
        StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsReg,   // add/sub/and/or
        ClsImm,   // addi/andi/ori
        ClsLdi,
        ClsLd,
        ClsSt,
        ClsBr,
        ClsJr,
        ClsNop,   // nop and every unassigned opcode
        ClsHalt
    } iclass_e;

    typedef struct packed {
        logic pc_out;
        logic zhi_out;
        logic zlow_out;
        logic mdr_out;
        logic inport_out;
        logic c_out;
        logic ba_out;
        logic r_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic outport_in;
        logic r_in;
        logic con_in;
        logic gra;
        logic grb;
        logic grc;
        logic inc_pc;
        logic read;
        logic write;
    } ctrl_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Interface ctrl_sequencer_if: control bus between the sequencer and the datapath.
//   IR, CON              datapath -> sequencer (instruction register, branch flag)
//   *out selects         sequencer -> datapath bus-drive selects
//   *in enables          sequencer -> datapath register load enables
//   Gra/Grb/Grc          register-field selects
//   IncPC/Read/Write     PC increment and memory strobes
//   alu_op               ALU function, meaningful only while Zin=1
//   Run                  1 while executing, 0 after halt (or while stopped)
// Modports: master = sequencer side, slave = datapath side.
interface ctrl_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [IR_W-1:0] IR;
    logic            CON;

    logic PCout, Zhiout, Zlowout, MDRout, InPortout, Cout, BAout, Rout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, CONIn;
    logic Gra, Grb, Grc, IncPC, Read, Write;
    logic [3:0] alu_op;
    logic Run;

    modport master (
        input  IR, CON,
        output PCout, Zhiout, Zlowout, MDRout, InPortout, Cout, BAout, Rout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, CONIn,
        output Gra, Grb, Grc, IncPC, Read, Write, alu_op, Run
    );

    modport slave (
        output IR, CON,
        input  PCout, Zhiout, Zlowout, MDRout, InPortout, Cout, BAout, Rout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, CONIn,
        input  Gra, Grb, Grc, IncPC, Read, Write, alu_op, Run
    );

endinterface

// File: rtl/ctrl_sequencer_decode.sv
// Module ctrl_decode: combinational opcode decoder.
//   opcode_i  5-bit opcode field IR[31:27]
//   iclass_o  instruction class steering the execute steps
//   alu_op_o  ALU function used in the T4 Zin step (ADD for address/branch arithmetic)
// Unassigned opcodes decode as nop.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output iclass_e          iclass_o,
    output alu_op_e          alu_op_o
);

    always_comb begin
        iclass_o = ClsNop;
        alu_op_o = AluAdd;
        case (opcode_i)
            OpcLd:   iclass_o = ClsLd;
            OpcLdi:  iclass_o = ClsLdi;
            OpcSt:   iclass_o = ClsSt;
            OpcAdd:  iclass_o = ClsReg;
            OpcSub:  begin iclass_o = ClsReg; alu_op_o = AluSub; end
            OpcAnd:  begin iclass_o = ClsReg; alu_op_o = AluAnd; end
            OpcOr:   begin iclass_o = ClsReg; alu_op_o = AluOr;  end
            OpcAddi: iclass_o = ClsImm;
            OpcAndi: begin iclass_o = ClsImm; alu_op_o = AluAnd; end
            OpcOri:  begin iclass_o = ClsImm; alu_op_o = AluOr;  end
            OpcBr:   iclass_o = ClsBr;
            OpcJr:   iclass_o = ClsJr;
            OpcHalt: iclass_o = ClsHalt;
            default: iclass_o = ClsNop;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Module ctrl_sequencer: hardwired control unit.
// Runs a 3-step fetch (T0..T2) then an opcode-specific execute (T3..T7) and
// drives the datapath strobes as Moore outputs of the registered step.
// Ports:
//   Clock  system clock, rising edge
//   Clear  synchronous active-high reset (state -> RST, all strobes 0, Run=1)
//   Stop   (only with CTRL_STOP_EN) parks the FSM in T0 while high
//   bus    ctrl_sequencer_if.master: IR/CON in, all control strobes out
// Build option: define CTRL_STOP_EN to add the Stop input.
module ctrl_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic Clock,
    input  logic Clear,
`ifdef CTRL_STOP_EN
    input  logic Stop,
`endif
    ctrl_sequencer_if.master bus
);

    state_e  state_q, state_d;
    iclass_e iclass;
    alu_op_e dec_alu_op;
    ctrl_t   ctl;
    alu_op_e alu_op;
    logic    run;
    logic    stop_req;
    logic    stopped;

    ctrl_decode u_decode (
        .opcode_i (bus.IR[OPC_LSB+OPC_W-1:OPC_LSB]),
        .iclass_o (iclass),
        .alu_op_o (dec_alu_op)
    );

    // Operand fields are consumed by the datapath, not here.
    logic unused_ir;
    assign unused_ir = ^bus.IR[OPC_LSB-1:0];

`ifdef CTRL_STOP_EN
    logic hold_q, hold_d;

    // Stop is only honoured at the end of T0; hold_q marks a parked T0 with
    // strobes suppressed. When Stop drops, T0 is replayed once with its strobes.
    assign stop_req = Stop;
    assign hold_d   = (state_q == StT0) && Stop;

    always_ff @(posedge Clock) begin
        if (Clear) hold_q <= 1'b0;
        else       hold_q <= hold_d;
    end

    assign stopped = hold_q;
`else
    assign stop_req = 1'b0;
    assign stopped  = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Clear) state_q <= StRst;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRst: state_d = StT0;
            StT0:  state_d = (stop_req || stopped) ? StT0 : StT1;
            StT1:  state_d = StT2;
            StT2:  state_d = StT3;
            StT3: begin
                case (iclass)
                    ClsJr, ClsNop: state_d = StT0;
                    ClsHalt:       state_d = StHalt;
                    default:       state_d = StT4;
                endcase
            end
            StT4:  state_d = StT5;
            StT5: begin
                case (iclass)
                    ClsLd, ClsSt, ClsBr: state_d = StT6;
                    default:             state_d = StT0;
                endcase
            end
            StT6: begin
                case (iclass)
                    ClsLd, ClsSt: state_d = StT7;
                    default:      state_d = StT0;
                endcase
            end
            StT7:   state_d = StT0;
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    always_comb begin
        ctl    = '0;
        alu_op = AluAdd;
        run    = 1'b1;
        unique case (state_q)
            StRst: ;
            StT0: begin
                if (stopped) begin
                    run = 1'b0;
                end else begin
                    ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.z_in = 1'b1;
                end
            end
            StT1: begin
                ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1;
            end
            StT2: begin
                ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1;
            end
            StT3: begin
                case (iclass)
                    ClsReg, ClsImm: begin
                        ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    ClsLdi, ClsLd, ClsSt: begin
                        ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    ClsBr: begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1;
                    end
                    ClsJr: begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT4: begin
                case (iclass)
                    ClsReg: begin
                        ctl.grc = 1'b1; ctl.r_out = 1'b1; ctl.z_in = 1'b1; alu_op = dec_alu_op;
                    end
                    ClsImm, ClsLdi, ClsLd, ClsSt: begin
                        ctl.c_out = 1'b1; ctl.z_in = 1'b1; alu_op = dec_alu_op;
                    end
                    ClsBr: begin
                        ctl.pc_out = 1'b1; ctl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT5: begin
                case (iclass)
                    ClsReg, ClsImm, ClsLdi: begin
                        ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    end
                    ClsLd, ClsSt: begin
                        ctl.zlow_out = 1'b1; ctl.mar_in = 1'b1;
                    end
                    ClsBr: begin
                        ctl.c_out = 1'b1; ctl.z_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                case (iclass)
                    ClsLd: begin
                        ctl.read = 1'b1; ctl.mdr_in = 1'b1;
                    end
                    ClsSt: begin
                        ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.mdr_in = 1'b1;
                    end
                    ClsBr: begin
                        // Taken branch loads the target computed in T5.
                        ctl.zlow_out = bus.CON; ctl.pc_in = bus.CON;
                    end
                    default: ;
                endcase
            end
            StT7: begin
                case (iclass)
                    ClsLd: begin
                        ctl.mdr_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1;
                    end
                    ClsSt: ctl.write = 1'b1;
                    default: ;
                endcase
            end
            StHalt: run = 1'b0;
            default: ;
        endcase
    end

    assign bus.PCout     = ctl.pc_out;
    assign bus.Zhiout    = ctl.zhi_out;
    assign bus.Zlowout   = ctl.zlow_out;
    assign bus.MDRout    = ctl.mdr_out;
    assign bus.InPortout = ctl.inport_out;
    assign bus.Cout      = ctl.c_out;
    assign bus.BAout     = ctl.ba_out;
    assign bus.Rout      = ctl.r_out;
    assign bus.MARin     = ctl.mar_in;
    assign bus.Zin       = ctl.z_in;
    assign bus.PCin      = ctl.pc_in;
    assign bus.MDRin     = ctl.mdr_in;
    assign bus.IRin      = ctl.ir_in;
    assign bus.Yin       = ctl.y_in;
    assign bus.OutPortin = ctl.outport_in;
    assign bus.Rin       = ctl.r_in;
    assign bus.CONIn     = ctl.con_in;
    assign bus.Gra       = ctl.gra;
    assign bus.Grb       = ctl.grb;
    assign bus.Grc       = ctl.grc;
    assign bus.IncPC     = ctl.inc_pc;
    assign bus.Read      = ctl.read;
    assign bus.Write     = ctl.write;
    assign bus.alu_op    = alu_op;
    assign bus.Run       = run;

    bus_drive_onehot: assert property (@(posedge Clock)
        $onehot0({ctl.pc_out, ctl.zhi_out, ctl.zlow_out, ctl.mdr_out,
                  ctl.inport_out, ctl.c_out, ctl.ba_out, ctl.r_out}));

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer. A per-cycle schedule of inputs and expected strobe
// words is built up front from per-opcode step tables, then replayed; outputs
// are compared on the falling edge. A few entries also carry literal pins.
module tb_ctrl_sequencer;

    localparam logic [27:0] PCOUT   = 28'd1 << 0;
    localparam logic [27:0] ZLOW    = 28'd1 << 2;
    localparam logic [27:0] MDROUT  = 28'd1 << 3;
    localparam logic [27:0] COUT    = 28'd1 << 5;
    localparam logic [27:0] BAOUT   = 28'd1 << 6;
    localparam logic [27:0] ROUT    = 28'd1 << 7;
    localparam logic [27:0] MARIN   = 28'd1 << 8;
    localparam logic [27:0] ZIN     = 28'd1 << 9;
    localparam logic [27:0] PCIN    = 28'd1 << 10;
    localparam logic [27:0] MDRIN   = 28'd1 << 11;
    localparam logic [27:0] IRIN    = 28'd1 << 12;
    localparam logic [27:0] YIN     = 28'd1 << 13;
    localparam logic [27:0] RIN     = 28'd1 << 15;
    localparam logic [27:0] CONIN   = 28'd1 << 16;
    localparam logic [27:0] GRA     = 28'd1 << 17;
    localparam logic [27:0] GRB     = 28'd1 << 18;
    localparam logic [27:0] GRC     = 28'd1 << 19;
    localparam logic [27:0] INCPC   = 28'd1 << 20;
    localparam logic [27:0] READ    = 28'd1 << 21;
    localparam logic [27:0] WRITE   = 28'd1 << 22;
    localparam logic [27:0] ALU_SUB = 28'd1 << 23;
    localparam logic [27:0] ALU_AND = 28'd2 << 23;
    localparam logic [27:0] ALU_OR  = 28'd3 << 23;
    localparam logic [27:0] ALU_MSK = 28'hF << 23;
    localparam logic [27:0] RUN     = 28'd1 << 27;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        clr;
        logic        stp;
        logic [27:0] exp;
        logic        lit_en;
        logic [27:0] lit;
    } rec_t;

    logic Clock;
    logic Clear;
`ifdef CTRL_STOP_EN
    logic Stop;
`endif

    ctrl_sequencer_if bus ();

    ctrl_sequencer dut (
        .Clock (Clock),
        .Clear (Clear),
`ifdef CTRL_STOP_EN
        .Stop  (Stop),
`endif
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    rec_t        sched[$];
    rec_t        cur;
    int          cur_idx;
    logic        cur_valid;
    int          checks;
    int          errors;
    logic [27:0] tr [8];
    int          tr_n;
    int          base;

    function automatic logic [31:0] mk(input logic [4:0] o);
        return {o, 27'h010801A};
    endfunction

    // Expected strobe words, one per step, for one whole instruction.
    task automatic trace(input logic [31:0] ir, input logic con);
        logic [4:0]  opc;
        logic [27:0] a;
        opc = ir[31:27];
        tr[0] = PCOUT | MARIN | INCPC | ZIN;
        tr[1] = ZLOW | PCIN | READ | MDRIN;
        tr[2] = MDROUT | IRIN;
        for (int i = 3; i < 8; i++) tr[i] = '0;
        tr_n = 4;
        case (opc)
            5'b00100, 5'b00101, 5'b00110: a = (opc == 5'b00100) ? ALU_SUB :
                                              (opc == 5'b00101) ? ALU_AND : ALU_OR;
            5'b01100: a = ALU_AND;
            5'b01101: a = ALU_OR;
            default:  a = '0;
        endcase
        case (opc)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                tr[3] = GRB | ROUT | YIN; tr[4] = GRC | ROUT | ZIN | a;
                tr[5] = ZLOW | GRA | RIN; tr_n = 6;
            end
            5'b01011, 5'b01100, 5'b01101: begin
                tr[3] = GRB | ROUT | YIN; tr[4] = COUT | ZIN | a;
                tr[5] = ZLOW | GRA | RIN; tr_n = 6;
            end
            5'b00001: begin
                tr[3] = GRB | BAOUT | YIN; tr[4] = COUT | ZIN;
                tr[5] = ZLOW | GRA | RIN; tr_n = 6;
            end
            5'b00000: begin
                tr[3] = GRB | BAOUT | YIN; tr[4] = COUT | ZIN; tr[5] = ZLOW | MARIN;
                tr[6] = READ | MDRIN; tr[7] = MDROUT | GRA | RIN; tr_n = 8;
            end
            5'b00010: begin
                tr[3] = GRB | BAOUT | YIN; tr[4] = COUT | ZIN; tr[5] = ZLOW | MARIN;
                tr[6] = GRA | ROUT | MDRIN; tr[7] = WRITE; tr_n = 8;
            end
            5'b10010: begin
                tr[3] = GRA | ROUT | CONIN; tr[4] = PCOUT | YIN; tr[5] = COUT | ZIN;
                tr[6] = con ? (ZLOW | PCIN) : '0; tr_n = 7;
            end
            5'b10011: tr[3] = GRA | ROUT | PCIN;
            default:  tr[3] = '0;
        endcase
        for (int i = 0; i < tr_n; i++) tr[i] = tr[i] | RUN;
    endtask

    task automatic push(input logic [27:0] e, input logic [31:0] ir, input logic c,
                        input logic s);
        rec_t r;
        r.ir = ir; r.con = c; r.clr = 1'b0; r.stp = s;
        r.exp = e; r.lit_en = 1'b0; r.lit = '0;
        sched.push_back(r);
    endtask

    task automatic instr(input logic [31:0] ir, input logic con, input int nsteps);
        int n;
        trace(ir, con);
        n = (nsteps > 0 && nsteps < tr_n) ? nsteps : tr_n;
        base = sched.size();
        for (int i = 0; i < n; i++) push(tr[i], ir, con, 1'b0);
    endtask

    // Clear goes high in the last scheduled cycle and stays for n cycles.
    task automatic do_clear(input int n);
        if (sched.size() > 0) sched[sched.size()-1].clr = 1'b1;
        for (int i = 0; i < n - 1; i++) begin
            push(RUN, 32'h0, 1'b0, 1'b0);
            sched[sched.size()-1].clr = 1'b1;
        end
        push(RUN, 32'h0, 1'b0, 1'b0);
        base = sched.size() - 1;
    endtask

    task automatic pin(input int idx, input logic [27:0] lit);
        sched[idx].lit_en = 1'b1;
        sched[idx].lit    = lit;
    endtask

`ifdef CTRL_STOP_EN
    task automatic instr_stop(input logic [31:0] ir, input int nstop);
        trace(ir, 1'b0);
        base = sched.size();
        push(tr[0], ir, 1'b0, 1'b1);
        for (int i = 1; i < nstop; i++) push('0, ir, 1'b0, 1'b1);
        push('0, ir, 1'b0, 1'b0);
        for (int i = 0; i < tr_n; i++) push(tr[i], ir, 1'b0, 1'b0);
    endtask
`endif

    function automatic logic [27:0] dut_word();
        return {bus.Run, bus.alu_op, bus.Write, bus.Read, bus.IncPC, bus.Grc, bus.Grb,
                bus.Gra, bus.CONIn, bus.Rin, bus.OutPortin, bus.Yin, bus.IRin, bus.MDRin,
                bus.PCin, bus.Zin, bus.MARin, bus.Rout, bus.BAout, bus.Cout, bus.InPortout,
                bus.MDRout, bus.Zlowout, bus.Zhiout, bus.PCout};
    endfunction

    // alu_op is a don't-care whenever Zin is low.
    function automatic logic [27:0] masked(input logic [27:0] w, input logic [27:0] ref_w);
        return ((ref_w & ZIN) != 0) ? w : (w & ~ALU_MSK);
    endfunction

    always @(negedge Clock) begin
        if (cur_valid) begin
            logic [27:0] act;
            act = dut_word();
            checks = checks + 1;
            if (masked(act, cur.exp) !== masked(cur.exp, cur.exp)) begin
                errors = errors + 1;
                $display("FAIL trace cycle=%0d ir=%h got=%h want=%h",
                         cur_idx, cur.ir, act, cur.exp);
            end
            if (cur.lit_en) begin
                checks = checks + 1;
                if (masked(act, cur.lit) !== masked(cur.lit, cur.lit)) begin
                    errors = errors + 1;
                    $display("FAIL pin cycle=%0d ir=%h got=%h want=%h",
                             cur_idx, cur.ir, act, cur.lit);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        cur_valid = 1'b0;
        cur_idx   = 0;
        Clear     = 1'b1;
        bus.IR    = '0;
        bus.CON   = 1'b0;
`ifdef CTRL_STOP_EN
        Stop      = 1'b0;
`endif

        // Reset for two cycles; T0 appears on the second cycle after release.
        do_clear(2);
        pin(0, RUN);
        pin(1, RUN);
        instr(32'h6108001A, 1'b0, 0);
        pin(base, PCOUT | MARIN | INCPC | ZIN | RUN);
        pin(base + 4, COUT | ZIN | ALU_AND | RUN);
        pin(base + 5, ZLOW | GRA | RIN | RUN);

        instr(mk(5'b00000), 1'b0, 0);
        pin(base + 2, MDROUT | IRIN | RUN);
        pin(base + 1, ZLOW | PCIN | READ | MDRIN | RUN);
        pin(base + 6, READ | MDRIN | RUN);
        pin(base + 7, MDROUT | GRA | RIN | RUN);

        instr(mk(5'b00011), 1'b0, 0);
        instr(mk(5'b00100), 1'b1, 0);
        pin(base + 4, GRC | ROUT | ZIN | ALU_SUB | RUN);
        instr(mk(5'b00101), 1'b0, 0);
        instr(mk(5'b00110), 1'b0, 0);
        instr(mk(5'b01011), 1'b0, 0);
        instr(mk(5'b01101), 1'b0, 0);
        instr(mk(5'b00001), 1'b0, 0);
        instr(mk(5'b00010), 1'b0, 0);
        pin(base + 7, WRITE | RUN);
        instr(mk(5'b10011), 1'b0, 0);
        instr(mk(5'b11010), 1'b0, 0);
        instr(mk(5'b11111), 1'b0, 0);
        pin(base + 3, RUN);

        instr(mk(5'b10010), 1'b0, 0);
        pin(base + 6, RUN);
        instr(mk(5'b10010), 1'b1, 0);
        pin(base + 6, ZLOW | PCIN | RUN);

        // Halt, idle a while, then Clear restarts at T0.
        instr(mk(5'b11011), 1'b0, 0);
        for (int i = 0; i < 4; i++) push('0, mk(5'b11011), 1'b0, 1'b0);
        pin(base + 4, 28'h0);
        do_clear(1);
        instr(mk(5'b00011), 1'b0, 0);
        pin(base, PCOUT | MARIN | INCPC | ZIN | RUN);

        // Clear during st T6: the T7 Write must never appear.
        instr(mk(5'b00010), 1'b0, 7);
        do_clear(1);
        pin(base, RUN);
        instr(mk(5'b01100), 1'b0, 0);

`ifdef CTRL_STOP_EN
        instr_stop(mk(5'b00011), 5);
        pin(base, PCOUT | MARIN | INCPC | ZIN | RUN);
        pin(base + 3, 28'h0);
        pin(base + 6, PCOUT | MARIN | INCPC | ZIN | RUN);
`endif

        for (int k = 0; k < sched.size(); k++) begin
            @(posedge Clock);
            #1;
            Clear   = sched[k].clr;
            bus.IR  = sched[k].ir;
            bus.CON = sched[k].con;
`ifdef CTRL_STOP_EN
            Stop    = sched[k].stp;
`endif
            cur       = sched[k];
            cur_idx   = k;
            cur_valid = 1'b1;
        end
        @(posedge Clock);
        #1;
        cur_valid = 1'b0;
        @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
